// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared opcodes, funct codes, FSM states and load/store decode helpers
package mem_access_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_JALR   = 6'h09;
    localparam logic [5:0] F_MTHI   = 6'h11;
    localparam logic [5:0] F_MTLO   = 6'h13;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_MULTU  = 6'h19;
    localparam logic [5:0] F_DIV    = 6'h1A;
    localparam logic [5:0] F_DIVU   = 6'h1B;
    typedef enum logic {IDLE, ACCESS} state_t;
    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction
    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: little-endian lane formatting (op, off, wsrc -> wdata, be) and load extraction (rsrc -> rdata)
module mem_align
    import mem_access_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wsrc,
    input  logic [31:0] rsrc,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] rdata
);
    logic byte_op, half_op;
    logic [7:0] b;
    logic [15:0] h;
    always_comb begin
        byte_op = op inside {OP_LB, OP_LBU, OP_SB};
        half_op = op inside {OP_LH, OP_LHU, OP_SH};
        b = rsrc[{off, 3'b000} +: 8];
        h = off[1] ? rsrc[31:16] : rsrc[15:0];
        wdata = byte_op ? {4{wsrc[7:0]}} : half_op ? {2{wsrc[15:0]}} : wsrc;
        be = byte_op ? 4'b0001 << off : half_op ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        rdata = op == OP_LB ? {{24{b[7]}}, b} : op == OP_LBU ? {24'b0, b} :
                op == OP_LH ? {{16{h[15]}}, h} : op == OP_LHU ? {16'b0, h} : rsrc;
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage; EX bundle (invalid/ins/result/rdata2/nextpc) -> data-memory handshake (dreq/dwe/daddr/dwdata/dbe/drdata/dack) -> registered writeback (wbvalid/wben/wbreg/wbdata/aderr)
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        invalid,
    input  logic [31:0] ins,
    input  logic [31:0] result,
    input  logic [31:0] rdata2,
    input  logic [31:0] nextpc,
    output logic        stall,
    output logic        dreq,
    output logic        dwe,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dbe,
    input  logic [31:0] drdata,
    input  logic        dack,
    output logic        wbvalid,
    output logic        wben,
    output logic [4:0]  wbreg,
    output logic [31:0] wbdata,
    output logic        aderr
);
    state_t state;
    logic [5:0] op, funct, op_q;
    logic [1:0] off_q;
    logic ld, st, mis, accept, wen, link;
    logic [4:0] dest;
    logic [31:0] al_wdata, al_rdata;
    logic [3:0] al_be;
    logic unused_fields;
    assign op = ins[31:26];
    assign funct = ins[5:0];
    assign unused_fields = ^{ins[25:21], ins[10:6]};
    always_comb begin
        ld = is_load(op);
        st = is_store(op);
        mis = (op inside {OP_LH, OP_LHU, OP_SH} && result[0]) || (op inside {OP_LW, OP_SW} && result[1:0] != 2'b00);
        accept = state == IDLE && invalid && (ld || st) && !mis;
        stall = !rst && (accept || (state == ACCESS && !dack));
        dest = op == OP_RTYPE ? ins[15:11] : op == OP_JAL ? 5'd31 : ins[20:16];
        link = op == OP_JAL || (op == OP_RTYPE && funct == F_JALR);
        wen = dest != 5'd0 && ((op == OP_RTYPE && !(funct inside {F_JR, F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU}))
              || (op >= OP_ADDI && op <= OP_XORI) || ld || op == OP_JAL);
    end
    // Stores are formatted from the live EX inputs while idle; loads are extracted from the captured op/offset during access.
    mem_align u_align (
        .op    (state == ACCESS ? op_q : op),
        .off   (state == ACCESS ? off_q : result[1:0]),
        .wsrc  (rdata2),
        .rsrc  (drdata),
        .wdata (al_wdata),
        .be    (al_be),
        .rdata (al_rdata)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dreq <= 1'b0;
            dwe <= 1'b0;
            daddr <= '0;
            dwdata <= '0;
            dbe <= '0;
            wbvalid <= 1'b0;
            wben <= 1'b0;
            wbreg <= '0;
            wbdata <= '0;
            aderr <= 1'b0;
            op_q <= '0;
            off_q <= '0;
        end else begin
            wbvalid <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    state <= ACCESS;
                    dreq <= 1'b1;
                    dwe <= st;
                    daddr <= {result[31:2], 2'b00};
                    dwdata <= al_wdata;
                    dbe <= al_be;
                    op_q <= op;
                    off_q <= result[1:0];
                    wbreg <= dest;
                    wben <= wen;
                    wbdata <= result;
                    aderr <= 1'b0;
                end else if (invalid) begin
                    wbvalid <= 1'b1;
                    wben <= wen && !mis;
                    wbreg <= dest;
                    wbdata <= link ? nextpc : result;
                    aderr <= mis;
                end
            end else if (dack) begin
                state <= IDLE;
                dreq <= 1'b0;
                dwe <= 1'b0;
                wbvalid <= 1'b1;
                if (is_load(op_q)) wbdata <= al_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scoreboard bench for mem_access
module tb_mem_access;
    import mem_access_pkg::*;
    logic clk = 1'b0, rst = 1'b1, invalid = 1'b0, dack = 1'b0;
    logic [31:0] ins = '0, result = '0, rdata2 = '0, nextpc = '0, drdata = '0;
    logic stall, dreq, dwe, wbvalid, wben, aderr;
    logic [31:0] daddr, dwdata, wbdata;
    logic [3:0] dbe;
    logic [4:0] wbreg;
    typedef struct {logic en; logic [4:0] rg; logic [31:0] data; logic ae; logic full;} wb_t;
    wb_t sb[$];
    int n_cmp = 0, n_bad = 0;
    mem_access dut (
        .clk(clk), .rst(rst), .invalid(invalid), .ins(ins), .result(result), .rdata2(rdata2),
        .nextpc(nextpc), .stall(stall), .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .dbe(dbe), .drdata(drdata), .dack(dack), .wbvalid(wbvalid), .wben(wben), .wbreg(wbreg),
        .wbdata(wbdata), .aderr(aderr)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {op, 5'd1, rt, rd, 5'd0, fn};
    endfunction
    task automatic exp_wb(input logic en, input logic [4:0] rg, input logic [31:0] data, input logic ae, input logic full);
        sb.push_back('{en, rg, data, ae, full});
    endtask
    always @(negedge clk) begin
        wb_t e;
        if (!rst && wbvalid) begin
            if (sb.size() == 0) chk("unexpected_wbvalid", 32'(wbvalid), 32'd0);
            else begin
                e = sb.pop_front();
                chk("wben", 32'(wben), 32'(e.en));
                chk("aderr", 32'(aderr), 32'(e.ae));
                if (e.full) begin
                    chk("wbreg", 32'(wbreg), 32'(e.rg));
                    chk("wbdata", wbdata, e.data);
                end
            end
        end
    end
    task automatic mem_op(input string tag, input logic [31:0] i, input logic [31:0] r, input logic [31:0] d2,
                          input logic [31:0] rd, input int waits, input logic [31:0] addr, input logic [3:0] be,
                          input logic we, input logic [31:0] wd, input logic [31:0] wmask);
        invalid = 1'b1; ins = i; result = r; rdata2 = d2;
        for (int c = 0; c < waits; c++) begin
            @(negedge clk);
            chk({tag, "_stall"}, 32'(stall), 32'd1);
            if (c > 0) begin
                chk({tag, "_dreq"}, 32'(dreq), 32'd1);
                chk({tag, "_daddr"}, daddr, addr);
            end
            tick;
        end
        dack = 1'b1; drdata = rd;
        @(negedge clk);
        chk({tag, "_stall_ack"}, 32'(stall), 32'd0);
        chk({tag, "_dreq_ack"}, 32'(dreq), 32'd1);
        chk({tag, "_daddr_ack"}, daddr, addr);
        chk({tag, "_dbe"}, 32'(dbe), 32'(be));
        chk({tag, "_dwe"}, 32'(dwe), 32'(we));
        chk({tag, "_dwdata"}, dwdata & wmask, wd & wmask);
        tick;
        dack = 1'b0; invalid = 1'b0; drdata = '0;
        chk({tag, "_wbvalid"}, 32'(wbvalid), 32'd1);
        chk({tag, "_dreq_done"}, 32'(dreq), 32'd0);
    endtask
    task automatic alu_op(input string tag, input logic [31:0] i, input logic [31:0] r, input logic [31:0] npc);
        invalid = 1'b1; ins = i; result = r; nextpc = npc;
        @(negedge clk);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_dreq"}, 32'(dreq), 32'd0);
        tick;
        invalid = 1'b0;
        chk({tag, "_wbvalid"}, 32'(wbvalid), 32'd1);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dreq", 32'(dreq), 32'd0);
        chk("rst_dwe", 32'(dwe), 32'd0);
        chk("rst_wbvalid", 32'(wbvalid), 32'd0);
        chk("rst_wben", 32'(wben), 32'd0);
        chk("rst_aderr", 32'(aderr), 32'd0);
        chk("rst_wbreg", 32'(wbreg), 32'd0);
        chk("rst_wbdata", wbdata, 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        chk("rst_dwdata", dwdata, 32'd0);
        chk("rst_dbe", 32'(dbe), 32'd0);
        tick;
        rst = 1'b0;
        tick;
        exp_wb(1'b1, 5'd5, 32'h89ABCDEF, 1'b0, 1'b1);
        mem_op("lw", mk(OP_LW, 5'd5, 5'd0, 6'd0), 32'h100, 32'h0, 32'h89ABCDEF, 3, 32'h100, 4'b1111, 1'b0, 32'h0, 32'h0);
        exp_wb(1'b1, 5'd6, 32'hFFFFFF80, 1'b0, 1'b1);
        mem_op("lb", mk(OP_LB, 5'd6, 5'd0, 6'd0), 32'h103, 32'h0, 32'h80112233, 1, 32'h100, 4'b1000, 1'b0, 32'h0, 32'h0);
        exp_wb(1'b1, 5'd7, 32'h00000080, 1'b0, 1'b1);
        mem_op("lbu", mk(OP_LBU, 5'd7, 5'd0, 6'd0), 32'h103, 32'h0, 32'h80112233, 2, 32'h100, 4'b1000, 1'b0, 32'h0, 32'h0);
        exp_wb(1'b0, 5'd8, 32'h0, 1'b0, 1'b0);
        mem_op("sh", mk(OP_SH, 5'd8, 5'd0, 6'd0), 32'h202, 32'h0000BEEF, 32'h0, 2, 32'h200, 4'b1100, 1'b1, 32'hBEEF0000, 32'hFFFF0000);
        exp_wb(1'b1, 5'd9, 32'hFFFF8001, 1'b0, 1'b1);
        mem_op("lh", mk(OP_LH, 5'd9, 5'd0, 6'd0), 32'h402, 32'h0, 32'h80017FFF, 1, 32'h400, 4'b1100, 1'b0, 32'h0, 32'h0);
        exp_wb(1'b1, 5'd11, 32'h00007FFF, 1'b0, 1'b1);
        mem_op("lhu", mk(OP_LHU, 5'd11, 5'd0, 6'd0), 32'h400, 32'h0, 32'h80017FFF, 1, 32'h400, 4'b0011, 1'b0, 32'h0, 32'h0);
        exp_wb(1'b0, 5'd12, 32'h0, 1'b0, 1'b0);
        mem_op("sb", mk(OP_SB, 5'd12, 5'd0, 6'd0), 32'h301, 32'h000000A5, 32'h0, 1, 32'h300, 4'b0010, 1'b1, 32'h0000A500, 32'h0000FF00);
        exp_wb(1'b0, 5'd13, 32'h0, 1'b0, 1'b0);
        mem_op("sw", mk(OP_SW, 5'd13, 5'd0, 6'd0), 32'h300, 32'h12345678, 32'h0, 2, 32'h300, 4'b1111, 1'b1, 32'h12345678, 32'hFFFFFFFF);
        exp_wb(1'b0, 5'd0, 32'h5, 1'b0, 1'b1);
        mem_op("lw_r0", mk(OP_LW, 5'd0, 5'd0, 6'd0), 32'h104, 32'h0, 32'h5, 1, 32'h104, 4'b1111, 1'b0, 32'h0, 32'h0);
        exp_wb(1'b0, 5'd5, 32'h0, 1'b1, 1'b0);
        alu_op("lw_mis", mk(OP_LW, 5'd5, 5'd0, 6'd0), 32'h101, 32'h0);
        exp_wb(1'b0, 5'd8, 32'h0, 1'b1, 1'b0);
        alu_op("sh_mis", mk(OP_SH, 5'd8, 5'd0, 6'd0), 32'h203, 32'h0);
        exp_wb(1'b0, 5'd9, 32'h0, 1'b1, 1'b0);
        alu_op("lhu_mis", mk(OP_LHU, 5'd9, 5'd0, 6'd0), 32'h401, 32'h0);
        exp_wb(1'b0, 5'd0, 32'h55, 1'b0, 1'b1);
        alu_op("addu_r0", mk(OP_RTYPE, 5'd2, 5'd0, 6'h21), 32'h55, 32'h0);
        exp_wb(1'b1, 5'd31, 32'h400, 1'b0, 1'b1);
        alu_op("jal", mk(OP_JAL, 5'd7, 5'd3, 6'd0), 32'h1230, 32'h400);
        exp_wb(1'b1, 5'd3, 32'h1234, 1'b0, 1'b1);
        alu_op("addu", mk(OP_RTYPE, 5'd2, 5'd3, 6'h21), 32'h1234, 32'h0);
        exp_wb(1'b1, 5'd4, 32'h77, 1'b0, 1'b1);
        alu_op("addi", mk(OP_ADDI, 5'd4, 5'd0, 6'd0), 32'h77, 32'h0);
        exp_wb(1'b0, 5'd9, 32'h0, 1'b0, 1'b0);
        alu_op("mult", mk(OP_RTYPE, 5'd2, 5'd9, F_MULT), 32'h66, 32'h0);
        exp_wb(1'b0, 5'd2, 32'h0, 1'b0, 1'b0);
        alu_op("beq", mk(6'h04, 5'd2, 5'd0, 6'd0), 32'h0, 32'h0);
        exp_wb(1'b1, 5'd2, 32'h888, 1'b0, 1'b1);
        alu_op("jalr", mk(OP_RTYPE, 5'd0, 5'd2, F_JALR), 32'h999, 32'h888);
        invalid = 1'b1; ins = mk(OP_LW, 5'd10, 5'd0, 6'd0); result = 32'h500;
        tick;
        @(negedge clk);
        chk("rstacc_dreq_before", 32'(dreq), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rstacc_dreq_now", 32'(dreq), 32'd0);
        invalid = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        dack = 1'b1; drdata = 32'hDEADBEEF;
        tick;
        dack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstacc_wbvalid", 32'(wbvalid), 32'd0);
            chk("rstacc_dreq", 32'(dreq), 32'd0);
            chk("rstacc_stall", 32'(stall), 32'd0);
        end
        tick;
        exp_wb(1'b1, 5'd3, 32'hABC, 1'b0, 1'b1);
        alu_op("post_rst", mk(OP_RTYPE, 5'd2, 5'd3, 6'h21), 32'hABC, 32'h0);
        repeat (3) tick;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
